// File: rtl/dsp_job_scheduler.sv
// dsp_job_scheduler: shares one dsp_top datapath between two requesters.
// Jobs are granted round-robin, the granted requester's samples and results
// are routed through, and every job ends in a done or error pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no job; arbitrate pending requests
// SETUP  | validate latched job, program dsp_mode, pulse start for FFT
// STREAM | pass granted requester's samples into the datapath
// DRAIN  | inputs finished; wait for results or FFT done, bounded
// DONE   | one-cycle job_done pulse
// ERR    | one-cycle job_err pulse (rejected job or drain timeout)
module dsp_job_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_W      = 8,
  parameter int FFT_N      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [3:0]              req_mode,
  input  logic [2*LEN_W-1:0]      req_len,
  input  logic [2*DATA_WIDTH-1:0] s_real,
  input  logic [2*DATA_WIDTH-1:0] s_imag,
  input  logic [1:0]              s_valid,
  output logic [1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]   m_real,
  output logic [DATA_WIDTH-1:0]   m_imag,
  output logic [1:0]              m_valid,
  output logic [1:0]              job_done,
  output logic [1:0]              job_err,
  output logic [1:0]              grant,
  output logic [1:0]              dsp_mode,
  output logic                    dsp_start,
  output logic [DATA_WIDTH-1:0]   dsp_din_real,
  output logic [DATA_WIDTH-1:0]   dsp_din_imag,
  output logic                    dsp_din_valid,
  input  logic                    dsp_din_ready,
  input  logic [DATA_WIDTH-1:0]   dsp_dout_real,
  input  logic [DATA_WIDTH-1:0]   dsp_dout_imag,
  input  logic                    dsp_dout_valid,
  input  logic                    dsp_done
);

  localparam logic [1:0] MODE_FFT = 2'd2;
  localparam logic [1:0] MODE_BAD = 2'd3;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STREAM, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic             g;
  logic             rr_ptr;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] out_cnt;
  logic [TMR_W-1:0] drain_tmr;

  logic                  pick;
  logic [1:0]            pick_mode;
  logic [LEN_W-1:0]      pick_len;
  logic                  is_fft;
  logic                  job_ok;
  logic                  g_ready;
  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_real;
  logic [DATA_WIDTH-1:0] g_imag;
  logic                  xfer;
  logic                  last_in;
  logic                  finished;

  // requester nearest rr_ptr wins; only meaningful when some req is set
  assign pick      = req[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign pick_mode = pick ? req_mode[3:2] : req_mode[1:0];
  assign pick_len  = pick ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

  assign is_fft  = (mode_q == MODE_FFT);
  assign job_ok  = (mode_q != MODE_BAD) && (len_q != '0) &&
                   !(is_fft && (len_q != LEN_W'(FFT_N)));
  // FIR/IIR accept a sample every cycle; FFT applies backpressure
  assign g_ready = is_fft ? dsp_din_ready : 1'b1;
  assign g_valid = g ? s_valid[1] : s_valid[0];
  assign g_real  = g ? s_real[2*DATA_WIDTH-1:DATA_WIDTH] : s_real[DATA_WIDTH-1:0];
  assign g_imag  = g ? s_imag[2*DATA_WIDTH-1:DATA_WIDTH] : s_imag[DATA_WIDTH-1:0];
  assign xfer    = (state == S_STREAM) && g_valid && g_ready;
  assign last_in = (in_cnt == (len_q - LEN_W'(1)));
  assign finished = is_fft ? dsp_done : (out_cnt == len_q);

  assign m_real = dsp_dout_real;
  assign m_imag = dsp_dout_imag;

  // state register, job latch, counters and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      g         <= 1'b0;
      rr_ptr    <= 1'b0;
      mode_q    <= MODE_BAD;
      len_q     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      drain_tmr <= '0;
      grant     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (|req) begin
            g      <= pick;
            mode_q <= pick_mode;
            len_q  <= pick_len;
            grant  <= pick ? 2'b10 : 2'b01;
          end
        end
        S_SETUP: begin
          in_cnt    <= '0;
          out_cnt   <= '0;
          drain_tmr <= TMR_W'(TIMEOUT - 1);
        end
        S_STREAM: begin
          if (xfer) in_cnt <= in_cnt + LEN_W'(1);
        end
        S_DRAIN: begin
          if (drain_tmr != '0) drain_tmr <= drain_tmr - TMR_W'(1);
        end
        S_DONE, S_ERR: begin
          rr_ptr <= ~g;
          grant  <= '0;
        end
        default: ;
      endcase
      if ((state == S_STREAM || state == S_DRAIN) && dsp_dout_valid && (out_cnt != len_q))
        out_cnt <= out_cnt + LEN_W'(1);
    end
  end

  // next-state decode and per-state routing of the shared datapath
  always_comb begin
    state_nxt     = state;
    s_ready       = '0;
    m_valid       = '0;
    job_done      = '0;
    job_err       = '0;
    dsp_mode      = MODE_BAD;
    dsp_start     = 1'b0;
    dsp_din_real  = '0;
    dsp_din_imag  = '0;
    dsp_din_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        if (job_ok) begin
          dsp_mode  = mode_q;
          dsp_start = is_fft;
          state_nxt = S_STREAM;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_STREAM: begin
        dsp_mode      = mode_q;
        s_ready[g]    = g_ready;
        dsp_din_real  = g_real;
        dsp_din_imag  = g_imag;
        dsp_din_valid = g_valid;
        m_valid[g]    = dsp_dout_valid;
        if (xfer && last_in) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dsp_mode   = mode_q;
        m_valid[g] = dsp_dout_valid;
        if (finished)
          state_nxt = S_DONE;
        else if (drain_tmr == '0)
          state_nxt = S_ERR;
      end
      S_DONE: begin
        dsp_mode    = mode_q;
        job_done[g] = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_ERR: begin
        job_err[g] = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsp_job_scheduler.sv
// tb_dsp_job_scheduler: drives job requests and sample streams, models
// dsp_top (echo +1 on real, xor 0x00FF on imag, one-cycle latency, FFT done
// a few cycles after FFT_N samples) and checks results via a scoreboard.
module tb_dsp_job_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  req_mode;
  logic [15:0] req_len;
  logic [31:0] s_real, s_imag;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [15:0] m_real, m_imag;
  logic [1:0]  m_valid, job_done, job_err, grant, dsp_mode;
  logic        dsp_start;
  logic [15:0] dsp_din_real, dsp_din_imag;
  logic        dsp_din_valid;
  logic        dsp_din_ready;
  logic [15:0] dsp_dout_real = '0, dsp_dout_imag = '0;
  logic        dsp_dout_valid = 1'b0;
  logic        dsp_done = 1'b0;

  logic mute = 1'b0;
  int   fft_cnt = 0, fft_wait = 0;

  int          tests = 0, fails = 0;
  int          exp_rr = 0;
  logic [32:0] sb[$];
  int          grant_seq[$];
  logic [1:0]  j_mode[2];
  logic [7:0]  j_len[2];
  int          j_kind[2];   // 0 normal, 1 rejected, 2 drain timeout

  dsp_job_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_len(req_len),
    .s_real(s_real), .s_imag(s_imag), .s_valid(s_valid), .s_ready(s_ready),
    .m_real(m_real), .m_imag(m_imag), .m_valid(m_valid),
    .job_done(job_done), .job_err(job_err), .grant(grant),
    .dsp_mode(dsp_mode), .dsp_start(dsp_start),
    .dsp_din_real(dsp_din_real), .dsp_din_imag(dsp_din_imag),
    .dsp_din_valid(dsp_din_valid), .dsp_din_ready(dsp_din_ready),
    .dsp_dout_real(dsp_dout_real), .dsp_dout_imag(dsp_dout_imag),
    .dsp_dout_valid(dsp_dout_valid), .dsp_done(dsp_done)
  );

  always #5 clk = ~clk;

  // behavioural stand-in for dsp_top
  always @(posedge clk) begin
    dsp_dout_valid <= dsp_din_valid & dsp_din_ready & ~mute;
    dsp_dout_real  <= dsp_din_real + 16'd1;
    dsp_dout_imag  <= dsp_din_imag ^ 16'h00FF;
    if (dsp_start) begin
      fft_cnt  <= 0;
      fft_wait <= 0;
      dsp_done <= 1'b0;
    end else if (dsp_din_valid & dsp_din_ready) begin
      fft_cnt <= fft_cnt + 1;
    end else if (fft_cnt == 8 && !dsp_done) begin
      if (fft_wait == 3) dsp_done <= 1'b1;
      else fft_wait <= fft_wait + 1;
    end
  end

  function automatic logic [15:0] smp_re(int k, int i);
    return 16'(k * 256 + i + 1);
  endfunction

  function automatic logic [15:0] smp_im(int k, int i);
    return 16'(16'hA000 + k * 16 + i);
  endfunction

  task automatic run_jobs(input logic [1:0] act);
    int idx[2], mcnt[2], starts[2], dins[2], gcyc[2], dcyc[2];
    logic [1:0]  fin;
    logic [1:0]  prev_grant;
    logic        idle_chk;
    logic [32:0] e;
    int cyc, cur, pick, lat, exp_lat, exp_starts;
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; mcnt[k] = 0; starts[k] = 0; dins[k] = 0; gcyc[k] = 0; dcyc[k] = 0;
    end
    fin = ~act; prev_grant = '0; idle_chk = 1'b0; cyc = 0; cur = 0;
    @(negedge clk);
    req_mode = {j_mode[1], j_mode[0]};
    req_len  = {j_len[1], j_len[0]};
    req      = act;
    while (fin != 2'b11 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (idle_chk) begin
        tests++;
        if (grant !== 2'b00 || dsp_mode !== 2'd3) begin
          fails++;
          $display("FAIL idle_after_job: grant=%b dsp_mode=%0d, required grant=00 dsp_mode=3", grant, dsp_mode);
        end
        idle_chk = 1'b0;
      end
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        pick = req[exp_rr] ? exp_rr : 1 - exp_rr;
        tests++;
        if (grant !== (2'b01 << pick)) begin
          fails++;
          $display("FAIL grant_pick: grant=%b required=%b", grant, 2'b01 << pick);
        end
        cur = grant[1] ? 1 : 0;
        gcyc[cur] = cyc;
        grant_seq.push_back(cur);
      end
      prev_grant = grant;
      for (int k = 0; k < 2; k++) begin
        if (m_valid[k]) begin
          tests++;
          mcnt[k]++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL result_unexpected: m_valid[%0d] real=%h with empty scoreboard", k, m_real);
          end else begin
            e = sb.pop_front();
            if ({1'(k), m_real, m_imag} !== e) begin
              fails++;
              $display("FAIL result_data: got req%0d %h/%h, required req%0d %h/%h",
                       k, m_real, m_imag, e[32], e[31:16], e[15:0]);
            end
          end
        end
      end
      if (dsp_start) starts[cur]++;
      if (s_ready != 2'b00 && dsp_mode !== j_mode[cur]) begin
        tests++; fails++;
        $display("FAIL dsp_mode_stream: dsp_mode=%0d required=%0d", dsp_mode, j_mode[cur]);
      end
      if ((s_ready & ~grant) != 2'b00) begin
        tests++; fails++;
        $display("FAIL s_ready_ungranted: s_ready=%b grant=%b", s_ready, grant);
      end
      for (int k = 0; k < 2; k++) begin
        if (job_done[k]) begin
          exp_starts = (j_mode[k] == 2'd2) ? 1 : 0;
          tests++;
          if (j_kind[k] != 0 || mcnt[k] != int'(j_len[k]) || starts[k] != exp_starts) begin
            fails++;
            $display("FAIL job_done_%0d: kind=%0d results=%0d starts=%0d, required kind=0 results=%0d starts=%0d",
                     k, j_kind[k], mcnt[k], starts[k], j_len[k], exp_starts);
          end
        end
        if (job_err[k]) begin
          lat     = (j_kind[k] == 1) ? cyc - gcyc[k] : cyc - dcyc[k];
          exp_lat = (j_kind[k] == 1) ? 1 : 64;
          tests++;
          if (j_kind[k] == 0 || lat != exp_lat ||
              (j_kind[k] == 1 && (starts[k] != 0 || dins[k] != 0))) begin
            fails++;
            $display("FAIL job_err_%0d: kind=%0d latency=%0d starts=%0d din_valid=%0d, required error latency=%0d",
                     k, j_kind[k], lat, starts[k], dins[k], exp_lat);
          end
        end
        if (job_done[k] || job_err[k]) begin
          fin[k]   = 1'b1;
          req[k]   = 1'b0;
          exp_rr   = 1 - k;
          idle_chk = 1'b1;
        end
      end
      dsp_din_ready = (grant != 2'b00 && j_mode[cur] == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < 2; k++) begin
        s_valid[k] = req[k] && (idx[k] < int'(j_len[k]));
        s_real[k*16 +: 16] = smp_re(k, idx[k]);
        s_imag[k*16 +: 16] = smp_im(k, idx[k]);
      end
      #1;
      if (dsp_din_valid) dins[cur]++;
      if (j_mode[cur] == 2'd2 && s_ready[cur] && !dsp_din_ready) begin
        tests++; fails++;
        $display("FAIL fft_ready: s_ready[%0d]=1 while dsp_din_ready=0", cur);
      end
      for (int k = 0; k < 2; k++) begin
        if (s_valid[k] && s_ready[k]) begin
          if (k != cur) begin
            tests++; fails++;
            $display("FAIL transfer_owner: transfer on req%0d, required req%0d", k, cur);
          end
          sb.push_back({1'(k), smp_re(k, idx[k]) + 16'd1, smp_im(k, idx[k]) ^ 16'h00FF});
          idx[k]++;
          if (idx[k] == int'(j_len[k])) dcyc[k] = cyc + 1;
        end
      end
    end
    s_valid = 2'b00;
    tests++;
    if (fin != 2'b11) begin
      fails++;
      $display("FAIL job_timeout: finished=%b required=11 within cycle budget", fin);
    end
    if (j_kind[0] != 2 && j_kind[1] != 2) begin
      tests++;
      if (sb.size() != 0) begin
        fails++;
        $display("FAIL scoreboard_left: %0d results missing, required 0", sb.size());
      end
    end
    sb.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; req = '0; req_mode = '1; req_len = '0;
    s_real = '0; s_imag = '0; s_valid = '0; dsp_din_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (grant !== 2'b00 || dsp_mode !== 2'd3 || dsp_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: grant=%b dsp_mode=%0d dsp_start=%b, required 00/3/0", grant, dsp_mode, dsp_start);
    end
    tests++;
    if (s_ready !== 2'b00 || m_valid !== 2'b00 || dsp_din_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_stream: s_ready=%b m_valid=%b din_valid=%b, required 00/00/0", s_ready, m_valid, dsp_din_valid);
    end
    tests++;
    if (job_done !== 2'b00 || job_err !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags: job_done=%b job_err=%b, required 00/00", job_done, job_err);
    end
    rst = 1'b0;
    exp_rr = 0;
  endtask

  task automatic test_fir;
    j_mode[0] = 2'd0; j_len[0] = 8'd4; j_kind[0] = 0;
    j_mode[1] = 2'd0; j_len[1] = 8'd0; j_kind[1] = 0;
    run_jobs(2'b01);
  endtask

  task automatic test_fft;
    j_mode[1] = 2'd2; j_len[1] = 8'd8; j_kind[1] = 0;
    run_jobs(2'b10);
  endtask

  task automatic test_round_robin;
    grant_seq.delete();
    j_mode[0] = 2'd1; j_len[0] = 8'd2; j_kind[0] = 0;
    j_mode[1] = 2'd0; j_len[1] = 8'd3; j_kind[1] = 0;
    run_jobs(2'b11);
    tests++;
    if (grant_seq.size() != 2 || grant_seq[0] != 0 || grant_seq[1] != 1) begin
      fails++;
      $display("FAIL rr_order: %0d grants, first=%0d, required r0 then r1",
               grant_seq.size(), (grant_seq.size() > 0) ? grant_seq[0] : -1);
    end
  endtask

  task automatic test_reject;
    j_mode[1] = 2'd0; j_len[1] = 8'd0; j_kind[1] = 0;
    j_kind[0] = 1;
    j_mode[0] = 2'd2; j_len[0] = 8'd5; run_jobs(2'b01);
    j_mode[0] = 2'd3; j_len[0] = 8'd2; run_jobs(2'b01);
    j_mode[0] = 2'd0; j_len[0] = 8'd0; run_jobs(2'b01);
  endtask

  task automatic test_timeout;
    mute = 1'b1;
    j_mode[0] = 2'd0; j_len[0] = 8'd3; j_kind[0] = 2;
    run_jobs(2'b01);
    mute = 1'b0;
    j_kind[0] = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    @(negedge clk);
    req_mode = 4'b0000; req_len = {8'd0, 8'd5}; req = 2'b01; dsp_din_ready = 1'b1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk);
      s_valid[0] = 1'b1;
      s_real[15:0] = smp_re(0, n);
      s_imag[15:0] = smp_im(0, n);
      #1;
      if (s_ready[0]) n++;
    end
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL reset_mid_setup: %0d transfers before reset, required 2", n);
    end
    @(negedge clk);
    rst = 1'b1; req = 2'b00; s_valid = 2'b00;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00 || dsp_mode !== 2'd3 || s_ready !== 2'b00 || m_valid !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid: grant=%b dsp_mode=%0d s_ready=%b m_valid=%b, required 00/3/00/00",
               grant, dsp_mode, s_ready, m_valid);
    end
    rst = 1'b0;
    exp_rr = 0;
    sb.delete();
    j_mode[0] = 2'd1; j_len[0] = 8'd3; j_kind[0] = 0;
    j_mode[1] = 2'd0; j_len[1] = 8'd0; j_kind[1] = 0;
    run_jobs(2'b01);
  endtask

  initial begin
    test_reset();
    test_fir();
    test_fft();
    test_round_robin();
    test_reject();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsp_job_scheduler.md
Name: dsp_job_scheduler

Overview:
- Shares one dsp_top instance (FIR/IIR/FFT datapath) between two requesters (NUM_REQ fixed at 2).
- Each requester submits a job: a mode plus a sample count. The scheduler grants jobs round-robin and drives dsp_top's mode and start signals.
- While a job runs, it routes that requester's sample stream into the datapath and routes results back.
- It tracks completion per mode, with a drain timeout, and pulses a per-requester done or error flag.

Parameters:
- DATA_WIDTH, 16, sample width for real and imag.
- LEN_W, 8, width of the job length field.
- FFT_N, 8, required job length for FFT jobs.
- TIMEOUT, 64, maximum cycles allowed in DRAIN before the job is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  2  job request per requester; held high until that requester's job_done or job_err.
- req_mode  in  4  {mode1, mode0}. Mode encoding: 0=FIR, 1=IIR, 2=FFT, 3=invalid.
- req_len  in  2*LEN_W  {len1, len0}; number of input samples in the job.
- s_real  in  2*DATA_WIDTH  per-requester input sample, real part.
- s_imag  in  2*DATA_WIDTH  per-requester input sample, imag part.
- s_valid  in  2  per-requester input valid.
- s_ready  out  2  per-requester input ready.
- m_real  out  DATA_WIDTH  result real part, shared by both requesters.
- m_imag  out  DATA_WIDTH  result imag part, shared by both requesters.
- m_valid  out  2  per-requester result valid.
- job_done  out  2  one-cycle pulse when a job completes.
- job_err  out  2  one-cycle pulse on job reject or timeout.
- grant  out  2  one-hot registered grant; all zero when idle.
- dsp_mode  out  2  mode driven to dsp_top.
- dsp_start  out  1  start pulse to dsp_top.
- dsp_din_real  out  DATA_WIDTH  sample to dsp_top, real part.
- dsp_din_imag  out  DATA_WIDTH  sample to dsp_top, imag part.
- dsp_din_valid  out  1  sample valid to dsp_top.
- dsp_din_ready  in  1  sample ready from dsp_top.
- dsp_dout_real  in  DATA_WIDTH  result from dsp_top, real part.
- dsp_dout_imag  in  DATA_WIDTH  result from dsp_top, imag part.
- dsp_dout_valid  in  1  result valid from dsp_top.
- dsp_done  in  1  FFT done level from dsp_top.

Behaviour:
Reset (synchronous, highest priority, also when asserted mid-job):
- state=IDLE; grant=0; dsp_mode=3; dsp_start=0.
- s_ready=0; m_valid=0; job_done=0; job_err=0; dsp_din_valid=0.
- rr_ptr=0, so requester 0 has priority first. All counters cleared.

State flow: IDLE -> SETUP -> STREAM -> DRAIN -> DONE -> IDLE. Any error path -> ERR -> IDLE.

IDLE:
- dsp_mode=3.
- If any req bit is set, grant the requester closest to rr_ptr (checking rr_ptr first, then the other one).
- Latch g, mode, and len; go to SETUP.

SETUP (1 cycle):
- Reject the job when any of the following holds: mode==3, len==0, or (mode==2 and len!=FFT_N). A rejected job goes to ERR.
- Otherwise drive dsp_mode=mode. For FFT, assert dsp_start=1 for this cycle only.
- Clear in_cnt and out_cnt; go to STREAM.

STREAM (combinational pass-through for the granted requester g):
- dsp_din_real/imag = s_real/imag[g].
- dsp_din_valid = s_valid[g].
- s_ready[g] = dsp_din_ready for FFT; s_ready[g] = 1 for FIR and IIR.
- s_ready of the non-granted requester stays 0.
- A transfer occurs on s_valid[g] & s_ready[g]; each transfer increments in_cnt.
- On the transfer where in_cnt==len-1, go to DRAIN.

Output routing (STREAM and DRAIN):
- m_real/imag = dsp_dout_real/imag.
- m_valid[g] = dsp_dout_valid; m_valid is 0 for the other requester and in all other states.
- Each dsp_dout_valid increments out_cnt (saturating at len).

DRAIN:
- dsp_din_valid=0.
- Completion condition: for FIR/IIR, out_cnt==len. For FFT, dsp_done==1 sampled in this state.
- FFT results keep streaming to m_* until dsp_done is sampled.
- A cycle counter counts up; if it reaches TIMEOUT, go to ERR.
- On completion, go to DONE.

DONE:
- job_done[g]=1 for one cycle.
- rr_ptr = ~g, so the other requester gets first priority next.
- grant clears on entry to IDLE; dsp_mode returns to 3.

ERR:
- job_err[g]=1 for one cycle.
- rr_ptr = ~g; return to IDLE.

Other rules:
- Both requests active in the same IDLE cycle are resolved by rr_ptr only; there is no starvation.
- req dropped mid-job is ignored; the job runs to completion.
- Length counters are LEN_W bits wide; len up to 2^LEN_W-1 is supported with no wrap.
- Latency: first dsp_din_valid can occur 2 cycles after req rises (IDLE, then SETUP).

Test Plan:
- Requester 0 submits an FIR job, len=4, samples 1,2,3,4 back-to-back -> dsp_mode=0 during the job, 4 m_valid[0] pulses, then job_done[0] pulse; grant returns to 0.
- Both req bits rise together (IIR len=2 on r0, FIR len=3 on r1) -> r0 granted first; after job_done[0], r1 granted; rr_ptr then favours r0.
- FFT job on r1, len=8 -> one dsp_start pulse in SETUP; s_ready[1] follows dsp_din_ready; 8 samples transferred; job_done[1] after dsp_done.
- Rejected jobs: FFT with len=5, mode=3, and len=0 -> each gives job_err pulse one cycle after grant, with no dsp_start and no dsp_din_valid.
- FIR len=3 with dsp_dout_valid held low by the bench -> job_err[0] asserted TIMEOUT (64) cycles after entering DRAIN.
- rst asserted during STREAM with in_cnt=2 -> next cycle grant=0, dsp_mode=3, s_ready=0; a new job afterwards runs normally.
